// File: rtl/johnson_code_decoder.sv
// Johnson code receiver: checks that a Johnson word is legal, decodes it to a
// binary index, verifies that successive words follow each other, locks onto
// a clean sequence and keeps a saturating count of errors.
//
// state  | meaning
// HUNT   | no trusted anchor; waiting for any legal word
// VERIFY | anchor held; counting consecutive correct successors
// LOCK   | LOCK_COUNT correct successors seen; sequence trusted
module johnson_code_decoder #(
  parameter  int N          = 8,
  parameter  int LOCK_COUNT = 4,
  parameter  int ERR_W      = 8,
  localparam int IW         = $clog2(2*N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     in_code,
  input  logic             clr_err,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             code_illegal,
  output logic             seq_error,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  anchor;
  logic [GW-1:0] good;

  int            trans;
  int            pop;
  logic          legal;
  logic [IW-1:0] dec;
  logic [N-1:0]  succ;
  logic          match;
  logic          seq_evt;
  logic          err_evt;
  logic [GW-1:0] good_inc;

  // Legality (at most one adjacent-bit transition) and index decode
  always_comb begin
    trans = 0;
    pop   = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (in_code[i] != in_code[i+1]) trans++;
    end
    for (int i = 0; i < N; i++) begin
      if (in_code[i]) pop++;
    end
    legal = (trans <= 1);
    if (in_code == '0)
      dec = '0;
    else if (in_code[N-1])
      dec = IW'(pop);
    else
      dec = IW'(2*N - pop);
    succ     = {~anchor[0], anchor[N-1:1]};
    match    = (in_code == succ);
    seq_evt  = in_valid && legal && (state != HUNT) && !match;
    err_evt  = (in_valid && !legal) || seq_evt;
    good_inc = good + 1'b1;
  end

  // Sequence FSM with registered index, pulses and lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      anchor       <= '0;
      good         <= '0;
      idx          <= '0;
      idx_valid    <= 1'b0;
      code_illegal <= 1'b0;
      seq_error    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      idx_valid    <= 1'b0;
      code_illegal <= 1'b0;
      seq_error    <= 1'b0;
      if (in_valid) begin
        if (!legal) begin
          code_illegal <= 1'b1;
          state        <= HUNT;
          good         <= '0;
          locked       <= 1'b0;
        end else begin
          idx       <= dec;
          idx_valid <= 1'b1;
          anchor    <= in_code;
          seq_error <= seq_evt;
          case (state)
            HUNT: begin
              state  <= VERIFY;
              good   <= '0;
              locked <= 1'b0;
            end
            VERIFY: begin
              if (match) begin
                good <= good_inc;
                if (good_inc == GW'(LOCK_COUNT)) begin
                  state  <= LOCK;
                  locked <= 1'b1;
                end
              end else begin
                good <= '0;
              end
            end
            LOCK: begin
              if (!match) begin
                state  <= VERIFY;
                good   <= '0;
                locked <= 1'b0;
              end
            end
            default: begin
              state  <= HUNT;
              good   <= '0;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Saturating error counter; clear has priority over a same-cycle error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (clr_err)
      err_count <= '0;
    else if (err_evt && (err_count != {ERR_W{1'b1}}))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_johnson_code_decoder.sv
// Directed bench for johnson_code_decoder with N=4, LOCK_COUNT=4, ERR_W=4.
module tb_johnson_code_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_code;
  logic       clr_err;
  logic [2:0] idx;
  logic       idx_valid;
  logic       code_illegal;
  logic       seq_error;
  logic       locked;
  logic [3:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  johnson_code_decoder #(.N(4), .LOCK_COUNT(4), .ERR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_code      (in_code),
    .clr_err      (clr_err),
    .idx          (idx),
    .idx_valid    (idx_valid),
    .code_illegal (code_illegal),
    .seq_error    (seq_error),
    .locked       (locked),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample, then check every output 1 ns after the capturing edge
  task automatic step(input logic v, input logic [3:0] code, input logic clr,
                      input string tag, input int e_idx, input logic e_iv,
                      input logic e_ill, input logic e_seq, input logic e_lock,
                      input int e_err);
    @(negedge clk);
    in_valid = v;
    in_code  = code;
    clr_err  = clr;
    @(posedge clk);
    #1;
    check({tag, ".idx"},       32'(idx),          32'(e_idx));
    check({tag, ".idx_valid"}, 32'(idx_valid),    32'(e_iv));
    check({tag, ".illegal"},   32'(code_illegal), 32'(e_ill));
    check({tag, ".seq_error"}, 32'(seq_error),    32'(e_seq));
    check({tag, ".locked"},    32'(locked),       32'(e_lock));
    check({tag, ".err_count"}, 32'(err_count),    32'(e_err));
  endtask

  initial begin
    int e;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = 4'b0000;
    clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.idx",       32'(idx),          0);
    check("rst.idx_valid", 32'(idx_valid),    0);
    check("rst.illegal",   32'(code_illegal), 0);
    check("rst.seq_error", 32'(seq_error),    0);
    check("rst.locked",    32'(locked),       0);
    check("rst.err_count", 32'(err_count),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: clean stream, lock after fourth good successor
    step(1, 4'b0001, 0, "t1a", 7, 1, 0, 0, 0, 0);
    step(1, 4'b0000, 0, "t1b", 0, 1, 0, 0, 0, 0);
    step(1, 4'b1000, 0, "t1c", 1, 1, 0, 0, 0, 0);
    step(1, 4'b1100, 0, "t1d", 2, 1, 0, 0, 0, 0);
    step(1, 4'b1110, 0, "t1e", 3, 1, 0, 0, 1, 0);

    // 2: illegal word while locked -> back to HUNT
    step(1, 4'b1010, 0, "t2a", 3, 0, 1, 0, 0, 1);
    // HUNT: a non-successor legal word raises no seq_error
    step(1, 4'b0011, 0, "t3a", 6, 1, 0, 0, 0, 1);

    // 3: relock ending at 1100, then a legal mismatch
    step(1, 4'b0001, 0, "t3b", 7, 1, 0, 0, 0, 1);
    step(1, 4'b0000, 0, "t3c", 0, 1, 0, 0, 0, 1);
    step(1, 4'b1000, 0, "t3d", 1, 1, 0, 0, 0, 1);
    step(1, 4'b1100, 0, "t3e", 2, 1, 0, 0, 1, 1);
    step(1, 4'b1111, 0, "t3f", 4, 1, 0, 1, 0, 2);
    step(1, 4'b0111, 0, "t3g", 5, 1, 0, 0, 0, 2);

    // 4: in_valid low holds everything, even with garbage on in_code
    for (int i = 0; i < 3; i++)
      step(0, 4'b1010, 0, "t4gap", 5, 0, 0, 0, 0, 2);
    step(1, 4'b0011, 0, "t4a", 6, 1, 0, 0, 0, 2);
    step(1, 4'b0001, 0, "t4b", 7, 1, 0, 0, 0, 2);
    step(1, 4'b0000, 0, "t4c", 0, 1, 0, 0, 1, 2);

    // 5: saturation at 15, then clear wins over a same-cycle error
    for (int i = 0; i < 16; i++) begin
      e = (3 + i > 15) ? 15 : 3 + i;
      step(1, 4'b0101, 0, "t5sat", 0, 0, 1, 0, 0, e);
    end
    step(1, 4'b1001, 1, "t5clr", 0, 0, 1, 0, 0, 0);

    // 6: lock again, then asynchronous reset between edges
    step(1, 4'b0000, 0, "t6a", 0, 1, 0, 0, 0, 0);
    step(1, 4'b1000, 0, "t6b", 1, 1, 0, 0, 0, 0);
    step(1, 4'b1100, 0, "t6c", 2, 1, 0, 0, 0, 0);
    step(1, 4'b1110, 0, "t6d", 3, 1, 0, 0, 0, 0);
    step(1, 4'b1111, 0, "t6e", 4, 1, 0, 0, 1, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6rst.idx",       32'(idx),          0);
    check("t6rst.idx_valid", 32'(idx_valid),    0);
    check("t6rst.locked",    32'(locked),       0);
    check("t6rst.err_count", 32'(err_count),    0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'b0011, 0, "t6f", 6, 1, 0, 0, 0, 0);
    // now in VERIFY with anchor 0011: a mismatch flags seq_error
    step(1, 4'b1000, 0, "t6g", 1, 1, 0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
